// File: rtl/dp_sqrt_arbiter.sv
// Round-robin arbiter sharing one combinational IEEE-754 double sqrt among N_REQ requesters.
// Latency: grant edge to rsp_valid is SETTLE cycles; issue interval is SETTLE+2 cycles minimum.
// Backpressure: response held stable until rsp_ready; no new grant while HOLD or RESP.

// Combinational double-precision square root, round-to-nearest-even.
module dp_sqrt (
    input  logic [63:0] x,
    output logic [63:0] y
);
    logic               sgn;
    logic [10:0]        ex;
    logic [51:0]        fr;
    logic [5:0]         sh;
    logic [53:0]        man;
    logic signed [12:0] e;
    logic [107:0]       rad;
    logic [57:0]        rem;
    logic [57:0]        trial;
    logic [52:0]        root;
    logic               inc;
    logic               ovf;
    logic [51:0]        frac;
    logic signed [12:0] er;
    logic [10:0]        eb;

    assign sgn = x[63];
    assign ex  = x[62:52];
    assign fr  = x[51:0];

    // Normalise the significand into [1,4) with an even unbiased exponent.
    always_comb begin
        sh = '0;
        for (int i = 0; i < 52; i++) begin
            if (fr[i]) sh = 6'(52 - i);
        end
        if (ex == 11'd0) begin
            man = {2'b00, fr} << sh;
            e   = -13'sd1022 - $signed({7'b0, sh});
        end else begin
            man = {2'b01, fr};
            e   = $signed({2'b00, ex}) - 13'sd1023;
        end
        if (e[0]) begin
            man = man << 1;
            e   = e - 13'sd1;
        end
        rad = {man, 54'b0};
    end

    // Restoring integer sqrt: 52 fraction bits plus one guard bit; the
    // always-set leading bit falls off the top of root on the last step.
    always_comb begin
        rem  = '0;
        root = '0;
        for (int i = 53; i >= 0; i--) begin
            rem   = {rem[55:0], rad[2*i +: 2]};
            trial = {3'b000, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[51:0], 1'b1};
            end else begin
                root = {root[51:0], 1'b0};
            end
        end
    end

    // Round, pack, and route special operands around the datapath.
    always_comb begin
        inc         = root[0] & ((|rem) | root[1]);
        {ovf, frac} = {1'b0, root[52:1]} + 53'(inc);
        er          = (e >>> 1) + $signed({12'b0, ovf});
        eb          = 11'(er + 13'sd1023);
        if (ex == 11'h7FF && fr != 52'd0) begin
            y = x | 64'h0008_0000_0000_0000;
        end else if (ex == 11'd0 && fr == 52'd0) begin
            y = x;
        end else if (sgn) begin
            y = 64'h7FF8_0000_0000_0000;
        end else if (ex == 11'h7FF) begin
            y = x;
        end else begin
            y = {1'b0, eb, frac};
        end
    end
endmodule

module dp_sqrt_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SETTLE = 4,
    parameter int ID_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [64*N_REQ-1:0]  req_x,
    output logic [N_REQ-1:0]     req_ack,
    output logic                 busy,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [63:0]          rsp_y
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t            state_q, state_d;
    logic [63:0]       op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              valid_q, valid_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [63:0]       y_q, y_d;

    logic              found;
    logic [ID_W-1:0]   gnt_idx;
    logic [4:0]        cand;
    logic [63:0]       sqrt_y;

    // op_q feeds the sqrt directly so the operand is stable for the whole multicycle window.
    dp_sqrt u_sqrt (
        .x (op_q),
        .y (sqrt_y)
    );

    // Round-robin pick: first set request after the last granted index.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {{(5-ID_W){1'b0}}, last_q} + 5'(k);
            if (cand >= 5'(N_REQ)) cand = cand - 5'(N_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    // Next-state logic for the grant / settle / respond sequence.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack_d   = '0;
        valid_d = valid_q;
        id_d    = id_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    op_d           = req_x[64*gnt_idx +: 64];
                    id_d           = gnt_idx;
                    last_d         = gnt_idx;
                    cnt_d          = CNT_W'(SETTLE - 1);
                    ack_d[gnt_idx] = 1'b1;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    y_d     = sqrt_y;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight operation and re-arms requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            ack_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            y_q     <= y_d;
        end
    end

    assign req_ack   = ack_q;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
endmodule

// File: tb/tb_dp_sqrt_arbiter.sv
module tb_dp_sqrt_arbiter;
    localparam int NV = 11;
    localparam logic [63:0] DECOY = 64'h4059_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [255:0] req_x;
    logic [3:0]   req_ack;
    logic         busy;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]   req;
        logic [255:0] x;
        logic [3:0]   ack;
        logic [1:0]   id;
        logic [63:0]  y;
        string        nm;
    } vec_t;

    vec_t        tbl [NV];
    logic [3:0]  a;
    int          n;
    int          na, nr;
    int          at [4];
    logic [3:0]  aa [4];
    logic [1:0]  rid [4];
    logic [63:0] ry [4];
    logic [63:0] rr_y [4];

    dp_sqrt_arbiter #(.N_REQ(4), .SETTLE(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .req_ack   (req_ack),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expired(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic wait_ack(input int lim, output logic [3:0] ack, output int cyc);
        ack = '0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (req_ack != 4'b0) begin
                ack = req_ack;
                cyc = i;
                return;
            end
        end
        cyc = lim + 1;
    endtask

    task automatic wait_valid(input int lim, output int cyc);
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = i;
                return;
            end
        end
        cyc = lim + 1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input int g, input logic [63:0] xv,
                                input logic [63:0] yv, input string nm);
        vec_t v;
        v.req = r;
        v.x   = {4{DECOY}};
        v.x[64*g +: 64] = xv;
        v.ack = 4'b0001 << g;
        v.id  = 2'(g);
        v.y   = yv;
        v.nm  = nm;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [3:0] ak;
        int c;
        @(negedge clk);
        req       = v.req;
        req_x     = v.x;
        rsp_ready = 1'b0;
        wait_ack(20, ak, c);
        if (c > 20) expired({v.nm, "_ack"});
        else chk({v.nm, "_ack"}, 64'(ak), 64'(v.ack));
        req = 4'b0;
        wait_valid(20, c);
        if (c > 20) begin
            expired({v.nm, "_valid"});
        end else begin
            chk({v.nm, "_lat"}, 64'(c), 64'd4);
            chk({v.nm, "_id"}, 64'(rsp_id), 64'(v.id));
            chk({v.nm, "_y"}, rsp_y, v.y);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({v.nm, "_release"}, {62'b0, rsp_valid, busy}, 64'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_x     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_y", rsp_y, 64'd0);
        rst = 1'b0;

        // Pointer starts at 3; each row's grant follows from the previous row's winner.
        tbl[0]  = mk(4'b0001, 0, 64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000, "v0_four");
        tbl[1]  = mk(4'b1000, 3, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, "v1_one");
        tbl[2]  = mk(4'b0110, 1, 64'h4000_0000_0000_0000, 64'h3FF6_A09E_667F_3BCD, "v2_two");
        tbl[3]  = mk(4'b0101, 2, 64'h3FD0_0000_0000_0000, 64'h3FE0_0000_0000_0000, "v3_quarter");
        tbl[4]  = mk(4'b1111, 3, 64'hBFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, "v4_neg");
        tbl[5]  = mk(4'b1001, 0, 64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, "v5_inf");
        tbl[6]  = mk(4'b1001, 3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "v6_negzero");
        tbl[7]  = mk(4'b0011, 0, 64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0001, "v7_nan");
        tbl[8]  = mk(4'b0100, 2, 64'h0000_0000_0000_0001, 64'h1E60_0000_0000_0000, "v8_subnorm");
        tbl[9]  = mk(4'b0011, 0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, "v9_zero");
        tbl[10] = mk(4'b1110, 1, 64'h4030_0000_0000_0000, 64'h4010_0000_0000_0000, "v10_sixteen");
        for (int i = 0; i < NV; i++) run_vec(tbl[i]);

        // Round-robin with all requesters held high and the consumer always ready.
        pulse_reset();
        rr_y  = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                  64'h4010_0000_0000_0000, 64'h4020_0000_0000_0000};
        req_x = {64'h4050_0000_0000_0000, 64'h4030_0000_0000_0000,
                 64'h4010_0000_0000_0000, 64'h3FF0_0000_0000_0000};
        req       = 4'b1111;
        rsp_ready = 1'b1;
        na = 0;
        nr = 0;
        for (int c = 0; c < 80 && nr < 4; c++) begin
            @(negedge clk);
            if (req_ack != 4'b0 && na < 4) begin
                aa[na] = req_ack;
                at[na] = c;
                na++;
            end
            if (rsp_valid) begin
                rid[nr] = rsp_id;
                ry[nr]  = rsp_y;
                nr++;
                if (nr == 4) req = 4'b0;
            end
        end
        if (na < 4 || nr < 4) begin
            expired("rr_sequence");
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rr_ack%0d", k), 64'(aa[k]), 64'(4'b0001 << k));
                chk($sformatf("rr_id%0d", k), 64'(rid[k]), 64'(k));
                chk($sformatf("rr_y%0d", k), ry[k], rr_y[k]);
                if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(at[k] - at[k-1]), 64'd6);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;

        // Backpressure plus operand hold: operand changes right after ack, consumer stalls 10 cycles.
        req_x = {DECOY, 64'h4022_0000_0000_0000, DECOY, 64'h3FF0_0000_0000_0000};
        req   = 4'b0100;
        wait_ack(20, a, n);
        if (n > 20) expired("bp_ack");
        else chk("bp_ack", 64'(a), 64'(4'b0100));
        req_x[128 +: 64] = 64'h4039_0000_0000_0000;
        req = 4'b0001;
        wait_valid(20, n);
        if (n > 20) expired("bp_valid");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_valid%0d", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_y%0d", i), rsp_y, 64'h4008_0000_0000_0000);
            chk($sformatf("bp_id%0d", i), 64'(rsp_id), 64'd2);
            chk($sformatf("bp_noack%0d", i), 64'(req_ack), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("bp_next_ack", 64'(req_ack), 64'(4'b0001));
        req = 4'b0;
        wait_valid(20, n);
        if (n > 20) expired("bp_drain");
        else chk("bp_drain_y", rsp_y, 64'h3FF0_0000_0000_0000);
        @(negedge clk);

        // Withdraw: requester 2 pulses for one cycle during HOLD and must not be served.
        req_x = {64'h4050_0000_0000_0000, DECOY, 64'h4010_0000_0000_0000, DECOY};
        req   = 4'b0010;
        wait_ack(20, a, n);
        if (n > 20) expired("wd_ack1");
        else chk("wd_ack1", 64'(a), 64'(4'b0010));
        req = 4'b0100;
        @(negedge clk);
        req = 4'b1000;
        wait_ack(30, a, n);
        if (n > 30) expired("wd_ack2");
        else chk("wd_ack2", 64'(a), 64'(4'b1000));
        req = 4'b0;
        wait_valid(20, n);
        if (n > 20) expired("wd_valid");
        else chk("wd_y", rsp_y, 64'h4020_0000_0000_0000);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in HOLD: nothing is returned and the pointer restarts at requester 0.
        req_x = {DECOY, DECOY, DECOY, 64'h4050_0000_0000_0000};
        req   = 4'b0100;
        wait_ack(20, a, n);
        if (n > 20) expired("ro_ack");
        else chk("ro_ack", 64'(a), 64'(4'b0100));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("ro_busy", 64'(busy), 64'd0);
        chk("ro_valid", 64'(rsp_valid), 64'd0);
        chk("ro_id", 64'(rsp_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ro_regrant", 64'(req_ack), 64'(4'b0001));
        chk("ro_no_rsp", 64'(rsp_valid), 64'd0);
        req       = 4'b0;
        rsp_ready = 1'b1;
        wait_valid(20, n);
        if (n > 20) begin
            expired("ro_valid2");
        end else begin
            chk("ro_y", rsp_y, 64'h4020_0000_0000_0000);
            chk("ro_id2", 64'(rsp_id), 64'd0);
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
